rvc_asap_dmem_arb: RTL and testbench
====================================

Name: rvc_asap_dmem_arb

Overview:
Two-requester arbiter sharing the single data memory port of the rvc_asap core between the core load/store path (requester 0) and a debug/loader DMA path (requester 1). It grants one request per cycle using round-robin priority. It drives a synchronous, fixed-latency SRAM and routes each read/write response back to the requester that owns it. It sits between the core/loader and the D_MEM macro that replaces the behavioural array.

Parameters:
MEM_LAT, 1, SRAM read latency in cycles (legal 1..4); also the response latency for writes.
CNT_W, 16, width of the saturating conflict counter.

Ports:
Clock  in  1  core clock, all logic on rising edge.
Rst  in  1  asynchronous, active-low reset.
ReqValid  in  2  per-requester request valid ([0]=core, [1]=loader).
ReqReady  out  2  per-requester grant; a transfer happens when ReqValid[i]&&ReqReady[i].
ReqAddr  in  2x32  byte address per requester.
ReqWrEn  in  2  1=store, 0=load.
ReqByteEn  in  2x4  byte enables (0001/0011/1111).
ReqWrData  in  2x32  store data.
RspValid  out  2  one-cycle response pulse to the owner.
RspRdData  out  32  read data, shared; qualified by RspValid.
MemEn  out  1  SRAM access enable.
MemWrEn  out  1  SRAM write enable.
MemAddr  out  32  SRAM address.
MemByteEn  out  4  SRAM byte enables.
MemWrData  out  32  SRAM write data.
MemRdData  in  32  SRAM read data, valid MEM_LAT cycles after MemEn.
ConflictCnt  out  CNT_W  cycles in which both requesters were valid.

Behaviour:
- Reset (Rst=0, async): ReqReady=0, RspValid=0, RspRdData=0, MemEn=0, MemWrEn=0, ConflictCnt=0, LastGrant=1, response pipeline cleared. Reset mid-transaction drops in-flight responses; no RspValid is issued for requests accepted before reset.
- Grant (combinational from ReqValid and LastGrant):
  - Only one valid requester: grant it.
  - Both valid: grant the index != LastGrant.
  - None valid: no grant.
  - At most one ReqReady bit is high per cycle. ReqReady is never high without the matching ReqValid.
- Issue, same cycle as the grant:
  - MemEn=1; MemAddr/MemWrEn/MemByteEn/MemWrData are muxed from the winner.
  - With no grant, MemEn=0 and the other Mem* outputs hold 0.
- LastGrant register updates to the winner's index on every grant and holds otherwise.
- Response pipeline:
  - Shift register of depth MEM_LAT; each entry is {valid, owner, isWrite}.
  - An accepted request enters at stage 0; the entry retires MEM_LAT cycles later.
  - On retire: RspValid[owner]=1 for one cycle. RspRdData=MemRdData for reads, 0 for writes.
  - Fully pipelined: back-to-back accepts every cycle are legal, with no bubbles.
- Requester protocol: once ReqValid is asserted, the requester holds it and its payload stable until ReqReady. The arbiter does not check this; the bench asserts it.
- ConflictCnt: increments when ReqValid==2'b11, saturates at all-ones, never wraps.
- Starvation bound: a continuously valid requester is granted within 2 cycles.
- Read-after-write between requesters to the same address: order follows grant order. SRAM write-first semantics are not relied upon.

Decomposition:
- rvc_asap_pkg gains:
  - t_arb_owner enum: CORE=1'b0, LOADER=1'b1.
  - t_rsp_entry packed struct {valid, owner, is_wr}.
  - Constant MEM_LAT_MAX=4.
- Sub-module rvc_asap_rr_arb2 contains the 2-way round-robin grant logic plus the LastGrant register. It outputs the 2-bit grant and the winner index.
- The response shift register, Mem* muxing and ConflictCnt stay in rvc_asap_dmem_arb.

Test Plan:
1. Reset, then only core reads addr 0x1000 (SRAM preloaded 0xDEADBEEF), MEM_LAT=1 -> ReqReady=01 same cycle; MemEn=1, MemAddr=0x1000; next cycle RspValid=01, RspRdData=0xDEADBEEF.
2. Both valid every cycle for 6 cycles after reset -> grants alternate 01,10,01,10,01,10 starting with core; ConflictCnt=6; RspValid follows the same pattern delayed MEM_LAT cycles.
3. Loader writes 0xCAFEF00D to 0x2000 (ByteEn 1111), then core reads 0x2000 the next cycle -> MemWrEn=1 then 0; loader gets RspValid with RspRdData=0; core reads 0xCAFEF00D.
4. MEM_LAT=3, core issues 4 back-to-back reads to 0x0,0x4,0x8,0xC -> 4 consecutive RspValid[0] pulses starting cycle 3, data in order, no bubbles.
5. Core read accepted, Rst pulsed low for 1 cycle before the response -> RspValid stays 0; ConflictCnt=0; first grant after reset goes to core.
6. Force ConflictCnt to 0xFFFE (CNT_W=16), hold both valid for 3 cycles -> counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap data-memory arbiter slice.
package rvc_asap_pkg;

   // Which requester owns a grant or an in-flight response
   typedef enum logic {
      CORE   = 1'b0,
      LOADER = 1'b1
   } t_arb_owner;

   // One stage of the response pipeline: an accepted access waiting for the SRAM
   typedef struct packed {
      logic       valid;
      t_arb_owner owner;
      logic       is_wr;
   } t_rsp_entry;

   // Deepest SRAM latency the response pipeline is meant to cover
   localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/rvc_asap_rr_arb2.sv
// Two-way round-robin arbiter: picks the requester that was not served last
// when both ask, and remembers the last winner.
module rvc_asap_rr_arb2
   import rvc_asap_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       winner
);

   t_arb_owner last_grant;

   // Grant decision: a lone requester always wins, a tie goes to the one not served last
   always_comb begin
      gnt    = 2'b00;
      winner = CORE;
      unique case (req)
         2'b01: begin
            gnt    = 2'b01;
            winner = CORE;
         end
         2'b10: begin
            gnt    = 2'b10;
            winner = LOADER;
         end
         2'b11: begin
            if (last_grant == LOADER) begin
               gnt    = 2'b01;
               winner = CORE;
            end else begin
               gnt    = 2'b10;
               winner = LOADER;
            end
         end
         default: begin
            gnt    = 2'b00;
            winner = CORE;
         end
      endcase
   end

   // Remember who won; resetting to LOADER makes the core win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LOADER;
      end else if (|gnt) begin
         last_grant <= t_arb_owner'(winner);
      end
   end

endmodule

// File: rtl/rvc_asap_dmem_arb.sv
// Shares the single data-memory port between the core load/store path and the
// loader DMA path, drives a fixed-latency SRAM and steers each response back
// to the requester that issued it.  MEM_LAT must stay within 1..MEM_LAT_MAX.
module rvc_asap_dmem_arb
   import rvc_asap_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0][31:0]  req_addr,
   input  logic [1:0]        req_wr_en,
   input  logic [1:0][3:0]   req_byte_en,
   input  logic [1:0][31:0]  req_wr_data,
   output logic [1:0]        rsp_valid,
   output logic [31:0]       rsp_rd_data,
   output logic              mem_en,
   output logic              mem_wr_en,
   output logic [31:0]       mem_addr,
   output logic [3:0]        mem_byte_en,
   output logic [31:0]       mem_wr_data,
   input  logic [31:0]       mem_rd_data,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic [1:0]  gnt;
   logic        winner;
   t_rsp_entry  pipe [MEM_LAT];
   t_rsp_entry  retire;

   rvc_asap_rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .gnt    (gnt),
      .winner (winner)
   );

   assign req_ready = gnt;

   // Route the winner's request to the SRAM in the grant cycle; idle bus reads as all zero
   always_comb begin
      mem_en      = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_byte_en = '0;
      mem_wr_data = '0;
      if (|gnt) begin
         mem_en      = 1'b1;
         mem_wr_en   = req_wr_en[winner];
         mem_addr    = req_addr[winner];
         mem_byte_en = req_byte_en[winner];
         mem_wr_data = req_wr_data[winner];
      end
   end

   // Track every accepted access for MEM_LAT cycles so its response lines up with SRAM data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= '{valid: (|gnt), owner: t_arb_owner'(winner), is_wr: mem_wr_en};
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign retire = pipe[MEM_LAT-1];

   // Retiring entry pulses its owner; write responses carry zero data
   always_comb begin
      rsp_valid   = 2'b00;
      rsp_rd_data = '0;
      if (retire.valid) begin
         rsp_valid[retire.owner] = 1'b1;
         if (!retire.is_wr) begin
            rsp_rd_data = mem_rd_data;
         end
      end
   end

   // Count cycles where both requesters compete, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if ((req_valid == 2'b11) && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rvc_asap_dmem_arb.sv
// Bench for rvc_asap_dmem_arb: two instances (latency 1 with a 16-bit counter,
// latency 3 with a 3-bit counter) share one stimulus stream and one SRAM image.
module tb_rvc_asap_dmem_arb;
   import rvc_asap_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
   } req_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0][31:0]  req_addr;
   logic [1:0]        req_wr_en;
   logic [1:0][3:0]   req_byte_en;
   logic [1:0][31:0]  req_wr_data;

   logic [1:0]  req_ready1, rsp_valid1, req_ready3, rsp_valid3;
   logic [31:0] rsp_rd_data1, rsp_rd_data3;
   logic        mem_en1, mem_wr_en1, mem_en3, mem_wr_en3;
   logic [31:0] mem_addr1, mem_wr_data1, mem_addr3, mem_wr_data3;
   logic [3:0]  mem_byte_en1, mem_byte_en3;
   logic [31:0] mem_rd_data1, mem_rd_data3;
   logic [15:0] conflict_cnt1;
   logic [2:0]  conflict_cnt3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rvc_asap_dmem_arb #(.MEM_LAT(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
      .req_addr(req_addr), .req_wr_en(req_wr_en), .req_byte_en(req_byte_en),
      .req_wr_data(req_wr_data), .rsp_valid(rsp_valid1), .rsp_rd_data(rsp_rd_data1),
      .mem_en(mem_en1), .mem_wr_en(mem_wr_en1), .mem_addr(mem_addr1),
      .mem_byte_en(mem_byte_en1), .mem_wr_data(mem_wr_data1),
      .mem_rd_data(mem_rd_data1), .conflict_cnt(conflict_cnt1)
   );

   rvc_asap_dmem_arb #(.MEM_LAT(3), .CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
      .req_addr(req_addr), .req_wr_en(req_wr_en), .req_byte_en(req_byte_en),
      .req_wr_data(req_wr_data), .rsp_valid(rsp_valid3), .rsp_rd_data(rsp_rd_data3),
      .mem_en(mem_en3), .mem_wr_en(mem_wr_en3), .mem_addr(mem_addr3),
      .mem_byte_en(mem_byte_en3), .mem_wr_data(mem_wr_data3),
      .mem_rd_data(mem_rd_data3), .conflict_cnt(conflict_cnt3)
   );

   function automatic logic [31:0] initWord(input int i);
      if (i == 32'h400) return 32'hDEAD_BEEF;
      return 32'hA500_0000 ^ (i * 32'h0000_9E37);
   endfunction

   // SRAM image behind the port: loaded on the first edge, written by dut1,
   // read data delayed by each instance's latency (junk returned for writes)
   logic [31:0] sram [0:4095];
   logic        loaded = 1'b0;
   logic [31:0] rdPipe1;
   logic [31:0] rdPipe3 [0:2];
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 4096; i++) sram[i] <= initWord(i);
         loaded <= 1'b1;
      end else if (mem_en1 && mem_wr_en1) begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_en1[b]) sram[mem_addr1[13:2]][8*b +: 8] <= mem_wr_data1[8*b +: 8];
      end
      rdPipe1    <= (mem_en1 && !mem_wr_en1) ? sram[mem_addr1[13:2]] : 32'h0BAD_0BAD;
      rdPipe3[0] <= (mem_en3 && !mem_wr_en3) ? sram[mem_addr3[13:2]] : 32'h0BAD_0BAD;
      rdPipe3[1] <= rdPipe3[0];
      rdPipe3[2] <= rdPipe3[1];
   end
   assign mem_rd_data1 = rdPipe1;
   assign mem_rd_data3 = rdPipe3[2];

   // Reference model state
   logic [31:0] refMem [0:4095];
   req_t        q0[$];
   req_t        q1[$];
   int          cyc = 0;
   int          epoch = 0;
   int          lastGrant = 1;
   int          conflicts = 0;
   bit          histValid [0:4095];
   int          histOwner [0:4095];
   bit          histWr    [0:4095];
   logic [31:0] histData  [0:4095];
   bit          prevValid [0:1];
   bit          prevGrant [0:1];
   req_t        prevReq   [0:1];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic req_t randReq();
      req_t r;
      int   k;
      r.addr = 32'h2000 + ($urandom_range(0, 7) << 2);
      r.wr   = 1'($urandom_range(0, 1));
      k      = $urandom_range(0, 2);
      r.be   = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
      r.data = $urandom;
      return r;
   endfunction

   function automatic req_t mkReq(input logic [31:0] a, input logic w, input logic [31:0] d);
      req_t r;
      r.addr = a; r.wr = w; r.be = 4'b1111; r.data = d;
      return r;
   endfunction

   task automatic expectRsp(input int lat, input logic [1:0] obsV, input logic [31:0] obsD,
                            input string tagV, input string tagD);
      int          a;
      logic [1:0]  ev;
      logic [31:0] ed;
      a  = cyc - lat;
      ev = 2'b00;
      ed = 32'h0;
      if (a >= epoch && a >= 0 && histValid[a]) begin
         ev = (histOwner[a] == 1) ? 2'b10 : 2'b01;
         ed = histWr[a] ? 32'h0 : histData[a];
      end
      checkOutput(tagV, 32'(obsV), 32'(ev));
      checkOutput(tagD, obsD, ed);
   endtask

   // Hold asynchronous reset for n cycles with requesters idle
   task automatic doReset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         req_valid = 2'b00;
         #1;
         checkOutput("rstReady1", 32'(req_ready1), 32'h0);
         checkOutput("rstRspV1", 32'(rsp_valid1), 32'h0);
         checkOutput("rstRspV3", 32'(rsp_valid3), 32'h0);
         checkOutput("rstRspD1", rsp_rd_data1, 32'h0);
         checkOutput("rstMemEn1", 32'(mem_en1), 32'h0);
         checkOutput("rstMemWrEn1", 32'(mem_wr_en1), 32'h0);
         checkOutput("rstCnt1", 32'(conflict_cnt1), 32'h0);
         @(posedge clk);
         histValid[cyc] = 1'b0;
         cyc++;
      end
      q0.delete();
      q1.delete();
      lastGrant = 1;
      conflicts = 0;
      prevValid[0] = 1'b0;
      prevValid[1] = 1'b0;
      epoch = cyc;
   endtask

   // mode 0: scripted queues only, 1: keep both requesters busy, 2: random traffic
   task automatic applyStimulus(input int n, input int mode);
      logic [1:0]  v, g;
      int          w;
      req_t        h [0:1];
      logic [31:0] ea, ed;
      logic [3:0]  eb;
      logic        ew;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if (mode == 1) begin
            if (q0.size() == 0) q0.push_back(randReq());
            if (q1.size() == 0) q1.push_back(randReq());
         end else if (mode == 2) begin
            if (q0.size() == 0 && $urandom_range(0, 99) < 60) q0.push_back(randReq());
            if (q1.size() == 0 && $urandom_range(0, 99) < 50) q1.push_back(randReq());
         end
         v = {1'(q1.size() > 0), 1'(q0.size() > 0)};
         h[0] = (v[0]) ? q0[0] : mkReq(32'h0, 1'b0, 32'h0);
         h[1] = (v[1]) ? q1[0] : mkReq(32'h0, 1'b0, 32'h0);
         req_valid = v;
         for (int r = 0; r < 2; r++) begin
            req_addr[r]    = h[r].addr;
            req_wr_en[r]   = h[r].wr;
            req_byte_en[r] = h[r].be;
            req_wr_data[r] = h[r].data;
            if (prevValid[r] && !prevGrant[r]) begin
               checkOutput("holdStable", {31'h0, v[r] && (h[r] == prevReq[r])}, 32'h1);
            end
         end
         #1;
         if (v == 2'b11)      w = (lastGrant == 1) ? 0 : 1;
         else if (v == 2'b01) w = 0;
         else if (v == 2'b10) w = 1;
         else                 w = -1;
         g  = (w < 0) ? 2'b00 : (w == 0) ? 2'b01 : 2'b10;
         ea = (w < 0) ? 32'h0 : h[w].addr;
         ew = (w < 0) ? 1'b0  : h[w].wr;
         eb = (w < 0) ? 4'h0  : h[w].be;
         ed = (w < 0) ? 32'h0 : h[w].data;
         checkOutput("ready1", 32'(req_ready1), 32'(g));
         checkOutput("ready3", 32'(req_ready3), 32'(g));
         checkOutput("memEn1", 32'(mem_en1), 32'(w >= 0));
         checkOutput("memWrEn1", 32'(mem_wr_en1), 32'(ew));
         checkOutput("memAddr1", mem_addr1, ea);
         checkOutput("memBe1", 32'(mem_byte_en1), 32'(eb));
         checkOutput("memWd1", mem_wr_data1, ed);
         checkOutput("memEn3", 32'(mem_en3), 32'(w >= 0));
         checkOutput("memAddr3", mem_addr3, ea);
         expectRsp(1, rsp_valid1, rsp_rd_data1, "rspValid1", "rspData1");
         expectRsp(3, rsp_valid3, rsp_rd_data3, "rspValid3", "rspData3");
         checkOutput("cnt1", 32'(conflict_cnt1), (conflicts > 65535) ? 32'd65535 : 32'(conflicts));
         checkOutput("cnt3", 32'(conflict_cnt3), (conflicts > 7) ? 32'd7 : 32'(conflicts));
         @(posedge clk);
         histValid[cyc] = (w >= 0);
         if (w >= 0) begin
            histOwner[cyc] = w;
            histWr[cyc]    = h[w].wr;
            histData[cyc]  = refMem[h[w].addr[13:2]];
            if (h[w].wr) begin
               for (int b = 0; b < 4; b++)
                  if (h[w].be[b]) refMem[h[w].addr[13:2]][8*b +: 8] = h[w].data[8*b +: 8];
            end
            if (w == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            lastGrant = w;
         end
         if (v == 2'b11) conflicts++;
         for (int r = 0; r < 2; r++) begin
            prevValid[r] = v[r];
            prevGrant[r] = g[r];
            prevReq[r]   = h[r];
         end
         cyc++;
      end
   endtask

   // Directed scenarios followed by a random soak
   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00;
      req_addr = '0;
      req_wr_en = '0;
      req_byte_en = '0;
      req_wr_data = '0;
      for (int i = 0; i < 4096; i++) begin
         refMem[i] = initWord(i);
         histValid[i] = 1'b0;
      end
      prevValid[0] = 1'b0;
      prevValid[1] = 1'b0;
      prevGrant[0] = 1'b0;
      prevGrant[1] = 1'b0;
      doReset(2);

      $display("[TB] single core read of preloaded word");
      q0.push_back(mkReq(32'h1000, 1'b0, 32'h0));
      applyStimulus(5, 0);

      $display("[TB] both requesters busy after reset");
      doReset(1);
      applyStimulus(6, 1);
      #1;
      checkOutput("conflict6", 32'(conflict_cnt1), 32'd6);
      applyStimulus(4, 0);

      $display("[TB] loader write then core read of same word");
      q1.push_back(mkReq(32'h2000, 1'b1, 32'hCAFE_F00D));
      applyStimulus(1, 0);
      q0.push_back(mkReq(32'h2000, 1'b0, 32'h0));
      applyStimulus(5, 0);

      $display("[TB] back-to-back core reads");
      for (int i = 0; i < 4; i++) q0.push_back(mkReq(32'(i * 4), 1'b0, 32'h0));
      applyStimulus(8, 0);

      $display("[TB] reset while a read is in flight");
      q0.push_back(mkReq(32'h1000, 1'b0, 32'h0));
      applyStimulus(1, 0);
      doReset(1);
      q0.push_back(mkReq(32'h0, 1'b0, 32'h0));
      q1.push_back(mkReq(32'h4, 1'b0, 32'h0));
      applyStimulus(6, 0);

      $display("[TB] conflict counter saturation");
      doReset(1);
      applyStimulus(10, 1);
      #1;
      checkOutput("satCnt3", 32'(conflict_cnt3), 32'd7);
      checkOutput("satCnt1", 32'(conflict_cnt1), 32'd10);
      applyStimulus(4, 0);

      $display("[TB] random traffic");
      applyStimulus(600, 2);
      applyStimulus(6, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
